dino_motion: RTL and testbench



---
 rtl/dino_motion.sv | 154 +++++++++++++++
 tb/tb_dino_motion.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_motion.sv
// ---------------------------------------------------------------------------
// dino_motion
//
// Upstream stage of the VGA controller. Turns the player buttons into dino
// sprite coordinates once per video frame, owns the game-start condition and
// the jump/duck physics, and freezes the sprite once the controller reports a
// collision.
//
// Ports:
//   clk        100 MHz system clock
//   reset      asynchronous active-high reset
//   up         jump/start button (asynchronous to clk)
//   down       duck/fast-fall button (asynchronous to clk)
//   screenEnd  frame-boundary pulse from the VGA controller (several clk wide)
//   game_over  sticky collision flag from the VGA controller
//   dino_x     sprite top-left x, zero-extended to 32 bits (constant)
//   dino_y     sprite top-left y, zero-extended to 32 bits
//   game_on    high once the game has started
//   jumping    high while airborne
//   ducking    high while running with down held
// ---------------------------------------------------------------------------
module dino_motion #(
  parameter int GROUND_Y = 275,
  parameter int DINO_X   = 50,
  parameter int MIN_Y    = 40,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int FASTFALL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        screenEnd,
  input  logic        game_over,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        game_on,
  output logic        jumping,
  output logic        ducking
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_AIR  = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic signed [10:0] MIN_S    = 11'(MIN_Y);

  logic [1:0]        state;
  logic [9:0]        pos_y;
  logic signed [7:0] velocity;
  logic              jump_pending;

  logic up_s1, up_s2, up_prev;
  logic down_s1, down_sync;
  logic screen_end_prev;

  logic              up_edge;
  logic              tick;
  logic signed [10:0] next_y;
  logic signed [7:0]  v_dec;

  // Two-flop synchronizers for the buttons plus the history flops used for
  // edge detection. screenEnd already comes from the controller's clock
  // domain tree, so only its previous value is needed to find the rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_s1           <= 1'b0;
      up_s2           <= 1'b0;
      up_prev         <= 1'b0;
      down_s1         <= 1'b0;
      down_sync       <= 1'b0;
      screen_end_prev <= 1'b0;
    end else begin
      up_s1           <= up;
      up_s2           <= up_s1;
      up_prev         <= up_s2;
      down_s1         <= down;
      down_sync       <= down_s1;
      screen_end_prev <= screenEnd;
    end
  end

  assign up_edge = up_s2 & ~up_prev;
  // One clk pulse per frame no matter how long screenEnd stays high.
  assign tick    = screenEnd & ~screen_end_prev;

  // Candidate position for this frame; 11-bit signed so that both an
  // overshoot below the ground and a rise above the top are representable.
  assign next_y = $signed({1'b0, pos_y}) - $signed({{3{velocity[7]}}, velocity});
  assign v_dec  = 8'(GRAVITY) + (down_sync ? 8'(FASTFALL) : 8'sd0);

  // Game state machine and physics. game_over outranks everything in RUN and
  // AIR, so a collision arriving with a frame tick freezes the pre-tick
  // position. The ceiling clamp zeroes velocity and then gravity still applies
  // on that same frame, so the dino immediately starts to come back down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_WAIT;
      pos_y        <= 10'(GROUND_Y);
      velocity     <= 8'sd0;
      jump_pending <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          // The start press only starts the game; it never queues a jump.
          if (up_edge) state <= ST_RUN;
        end
        ST_RUN: begin
          if (game_over) begin
            state <= ST_DEAD;
          end else begin
            if (up_edge) jump_pending <= 1'b1;
            if (tick && jump_pending) begin
              velocity     <= 8'(JUMP_V0);
              jump_pending <= 1'b0;
              state        <= ST_AIR;
            end
          end
        end
        ST_AIR: begin
          if (game_over) begin
            state <= ST_DEAD;
          end else if (tick) begin
            if (next_y >= GROUND_S) begin
              pos_y    <= 10'(GROUND_Y);
              velocity <= 8'sd0;
              state    <= ST_RUN;
            end else if (next_y < MIN_S) begin
              pos_y    <= 10'(MIN_Y);
              velocity <= 8'sd0 - v_dec;
            end else begin
              pos_y    <= next_y[9:0];
              velocity <= velocity - v_dec;
            end
          end
        end
        default: begin
          // DEAD: everything frozen until reset.
          state <= ST_DEAD;
        end
      endcase
    end
  end

  assign dino_x  = 32'(DINO_X);
  assign dino_y  = {22'd0, pos_y};
  assign game_on = (state != ST_WAIT);
  assign jumping = (state == ST_AIR);
  assign ducking = (state == ST_RUN) & down_sync;

endmodule

// File: tb/tb_dino_motion.sv
// ---------------------------------------------------------------------------
// tb_dino_motion
//
// Scoreboard bench for dino_motion. Two instances share the stimulus: one with
// the default launch velocity and one with JUMP_V0 = 40 so that the ceiling
// clamp is exercised. Each frame the stimulus process updates a frame-level
// physics model and pushes the expected post-tick outputs; a monitor triggered
// by the frame pulse pops and compares.
// ---------------------------------------------------------------------------
module tb_dino_motion;

  localparam int GROUND = 275;
  localparam int CEIL   = 40;
  localparam int XPOS   = 50;

  localparam int M_WAIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_AIR  = 2;
  localparam int M_DEAD = 3;

  logic clk = 1'b0;
  logic reset, up, down, screenEnd, game_over;

  logic [31:0] dino_x0, dino_y0, dino_x1, dino_y1;
  logic        game_on0, jumping0, ducking0;
  logic        game_on1, jumping1, ducking1;

  typedef struct {
    int y;
    int jumping;
    int ducking;
    int game_on;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level model state, one slot per instance.
  int m_mode[2];
  int m_y[2];
  int m_v[2];
  int m_pend[2];
  int m_v0[2] = '{12, 40};

  always #5 clk = ~clk;

  dino_motion u_dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .screenEnd(screenEnd),
    .game_over(game_over), .dino_x(dino_x0), .dino_y(dino_y0),
    .game_on(game_on0), .jumping(jumping0), .ducking(ducking0)
  );

  dino_motion #(.JUMP_V0(40)) u_dut_high (
    .clk(clk), .reset(reset), .up(up), .down(down), .screenEnd(screenEnd),
    .game_over(game_over), .dino_x(dino_x1), .dino_y(dino_y1),
    .game_on(game_on1), .jumping(jumping1), .ducking(ducking1)
  );

  task automatic compareVal(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_WAIT;
      m_y[i]    = GROUND;
      m_v[i]    = 0;
      m_pend[i] = 0;
    end
  endfunction

  // One frame of the game rules: button press first, then the collision flag,
  // then the frame tick; push what the outputs must show after the tick.
  function automatic void modelFrame(input int press, input int dn, input int go);
    exp_t e;
    int ny, dec;
    for (int i = 0; i < 2; i++) begin
      if (press != 0) begin
        if (m_mode[i] == M_WAIT)     m_mode[i] = M_RUN;
        else if (m_mode[i] == M_RUN) m_pend[i] = 1;
      end
      if (go != 0 && (m_mode[i] == M_RUN || m_mode[i] == M_AIR)) begin
        m_mode[i] = M_DEAD;
      end else if (m_mode[i] == M_RUN && m_pend[i] != 0) begin
        m_v[i]    = m_v0[i];
        m_pend[i] = 0;
        m_mode[i] = M_AIR;
      end else if (m_mode[i] == M_AIR) begin
        ny  = m_y[i] - m_v[i];
        dec = 1 + ((dn != 0) ? 2 : 0);
        if (ny >= GROUND) begin
          m_y[i] = GROUND;  m_v[i] = 0;  m_mode[i] = M_RUN;
        end else if (ny < CEIL) begin
          m_y[i] = CEIL;    m_v[i] = -dec;
        end else begin
          m_y[i] = ny;      m_v[i] = m_v[i] - dec;
        end
      end
      e.y       = m_y[i];
      e.jumping = (m_mode[i] == M_AIR) ? 1 : 0;
      e.ducking = (m_mode[i] == M_RUN && dn != 0) ? 1 : 0;
      e.game_on = (m_mode[i] != M_WAIT) ? 1 : 0;
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endfunction

  // Drive one frame: buttons, settle time, optional collision, then a
  // four-clk screenEnd pulse. Called at a falling edge.
  task automatic applyStimulus(input int press, input int dn, input int go);
    int gap;
    gap  = int'($urandom_range(3, 8));
    down = dn[0];
    if (press != 0) up = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i == 1) up = 1'b0;
    end
    if (go != 0) game_over = 1'b1;
    modelFrame(press, dn, int'(game_over));
    screenEnd = 1'b1;
    repeat (4) @(negedge clk);
    screenEnd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkOutput();
    exp_t e0, e1;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      compareVal("expect_queue_nonempty", 0, 1);
    end else begin
      e0 = exp_q0.pop_front();
      e1 = exp_q1.pop_front();
      compareVal("v12_dino_y",   int'(dino_y0),  e0.y);
      compareVal("v12_jumping",  int'(jumping0), e0.jumping);
      compareVal("v12_ducking",  int'(ducking0), e0.ducking);
      compareVal("v12_game_on",  int'(game_on0), e0.game_on);
      compareVal("v12_dino_x",   int'(dino_x0),  XPOS);
      compareVal("v40_dino_y",   int'(dino_y1),  e1.y);
      compareVal("v40_jumping",  int'(jumping1), e1.jumping);
      compareVal("v40_ducking",  int'(ducking1), e1.ducking);
      compareVal("v40_game_on",  int'(game_on1), e1.game_on);
    end
  endtask

  // Reset is checked 1 ns after assertion, before any clock edge, so the
  // asynchronous clear is what is being observed.
  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    game_over = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    #1;
    compareVal("reset_v12_dino_y",  int'(dino_y0),  GROUND);
    compareVal("reset_v12_jumping", int'(jumping0), 0);
    compareVal("reset_v12_game_on", int'(game_on0), 0);
    compareVal("reset_v40_dino_y",  int'(dino_y1),  GROUND);
    compareVal("reset_v40_game_on", int'(game_on1), 0);
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: the DUT updates one clk after the frame tick; sample two falling
  // edges after screenEnd rises.
  initial begin
    forever begin
      @(posedge screenEnd);
      repeat (2) @(negedge clk);
      checkOutput();
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    up        = 1'b0;
    down      = 1'b0;
    screenEnd = 1'b0;
    game_over = 1'b0;
    modelReset();
    doReset();

    // Idle in WAIT; a collision flag here must be ignored.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, (i == 4) ? 1 : 0);
    game_over = 1'b0;

    // Start the game; the start press must not launch a jump.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);

    // Plain jump: full arc for v0=12, ceiling clamp for v0=40.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0);

    // Jump, then hold down from the apex onwards and after landing.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 13; i++) applyStimulus(0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Presses while airborne are ignored.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0);

    // Randomized play.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? 1 : 0,
                    ($urandom_range(0, 2) == 0) ? 1 : 0, 0);
    end

    // Collision mid-jump together with a frame tick, then buttons are dead.
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
    end

    // Reset out of DEAD, restart, and reset again in the middle of a jump.
    doReset();
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);

    repeat (10) @(negedge clk);
    compareVal("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
